// File: rtl/mandelbrot_accel_pkg.sv
// mandelbrot_accel_pkg: shared widths, fixed-point constants and control bit indices
package mandelbrot_accel_pkg;
  localparam int W = 16;
  localparam int FRAC = 12;
  localparam int MAX_ITER_DEF = 127;
  localparam int START = 0;
  localparam int LOAD_CR = 1;
  localparam int LOAD_CI = 2;
  localparam logic signed [2*W:0] ESCAPE_THRESH = 33'sd1 <<< (2*FRAC + 2);
  typedef logic signed [W-1:0] q_t;
endpackage

// File: rtl/mandelbrot_accel_if.sv
// mandelbrot_accel_if: Tiny Tapeout style pin bundle between harness and user block
interface mandelbrot_accel_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  modport master (output ena, ui_in, uio_in, input uo_out, uio_out, uio_oe);
  modport slave (input ena, ui_in, uio_in, output uo_out, uio_out, uio_oe);
endinterface

// File: rtl/mandelbrot_accel_step.sv
// mandelbrot_accel_step: one z <- z^2 + c step in Q4.12 plus the |z|^2 > 4 escape test
module mandelbrot_step
  import mandelbrot_accel_pkg::*;
(
  input  q_t   zr,
  input  q_t   zi,
  input  q_t   cr,
  input  q_t   ci,
  output q_t   zr_nxt,
  output q_t   zi_nxt,
  output logic escape
);
  logic signed [2*W-1:0] zr2, zi2, zrzi;
  logic signed [2*W:0] mag, re, im;
  always_comb begin
    zr2 = 32'(zr) * 32'(zr);
    zi2 = 32'(zi) * 32'(zi);
    zrzi = 32'(zr) * 32'(zi);
    mag = 33'(zr2) + 33'(zi2);
    re = 33'(zr2) - 33'(zi2);
    im = 33'(zrzi) + 33'(zrzi);
    zr_nxt = W'(re >>> FRAC) + cr;
    zi_nxt = W'(im >>> FRAC) + ci;
    escape = mag > ESCAPE_THRESH;
  end
endmodule

// File: rtl/mandelbrot_accel.sv
// mandelbrot_accel: byte-loaded point c, one Mandelbrot iteration per clock, reports escape count
module mandelbrot_accel
  import mandelbrot_accel_pkg::*;
#(
  parameter int MAX_ITER = MAX_ITER_DEF
) (
  input logic clk,
  input logic rst_n,
  mandelbrot_accel_if.slave bus
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;
  logic [0:0] state;
  logic done, escape;
  logic [6:0] n;
  q_t cr, ci, zr, zi, zr_nxt, zi_nxt;
  logic unused;
  mandelbrot_step u_step (
    .zr(zr), .zi(zi), .cr(cr), .ci(ci),
    .zr_nxt(zr_nxt), .zi_nxt(zi_nxt), .escape(escape)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      done <= 1'b0;
      n <= '0;
      cr <= '0;
      ci <= '0;
      zr <= '0;
      zi <= '0;
    end else if (state == IDLE) begin
      if (bus.ui_in[LOAD_CR]) cr <= {cr[7:0], bus.uio_in};
      if (bus.ui_in[LOAD_CI]) ci <= {ci[7:0], bus.uio_in};
      if (bus.ui_in[START]) begin
        zr <= '0;
        zi <= '0;
        n <= '0;
        done <= 1'b0;
        state <= BUSY;
      end
    end else if (escape || n == 7'(MAX_ITER)) begin
      state <= IDLE;
      done <= 1'b1;
    end else begin
      zr <= zr_nxt;
      zi <= zi_nxt;
      n <= n + 7'd1;
    end
  assign bus.uo_out = {done, n};
  assign bus.uio_out = '0;
  assign bus.uio_oe = '0;
  assign unused = ^{bus.ena, bus.ui_in[7:3]};
endmodule

// File: tb/tb_mandelbrot_accel.sv
// tb_mandelbrot_accel: random and directed points checked cycle by cycle against an escape-count model
module tb_mandelbrot_accel;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  mandelbrot_accel_if bus ();
  mandelbrot_accel dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  function automatic int ref_count(input int cr, input int ci);
    longint zr = 0, zi = 0, t;
    for (int k = 0; k < 127; k++) begin
      if (zr * zr + zi * zi > 64'sd67108864) return k;
      t = ((zr * zr - zi * zi) >>> 12) + cr;
      zi = ((2 * zr * zi) >>> 12) + ci;
      zr = longint'(shortint'(t));
      zi = longint'(shortint'(zi));
    end
    return 127;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  logic [15:0] m_cr, m_ci, ncr, nci;
  logic m_busy, m_done;
  int m_n, m_res;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cr <= '0; m_ci <= '0; m_busy <= 1'b0; m_done <= 1'b0; m_n <= 0; m_res <= 0;
    end else if (!m_busy) begin
      ncr = bus.ui_in[1] ? {m_cr[7:0], bus.uio_in} : m_cr;
      nci = bus.ui_in[2] ? {m_ci[7:0], bus.uio_in} : m_ci;
      m_cr <= ncr;
      m_ci <= nci;
      if (bus.ui_in[0]) begin
        m_busy <= 1'b1; m_done <= 1'b0; m_n <= 0;
        m_res <= ref_count(int'(signed'(ncr)), int'(signed'(nci)));
      end
    end else if (m_n == m_res) begin
      m_busy <= 1'b0; m_done <= 1'b1;
    end else m_n <= m_n + 1;
  end

  always @(negedge clk) begin
    chk("uo_out_cycle", bus.uo_out, {m_done, 7'(m_n)});
    chk("uio_out", bus.uio_out, 8'h00);
    chk("uio_oe", bus.uio_oe, 8'h00);
  end

  task automatic drive(input logic [7:0] ui, input logic [7:0] d);
    bus.ui_in = ui;
    bus.uio_in = d;
    @(negedge clk);
    bus.ui_in = '0;
  endtask

  task automatic load(input logic [15:0] cr, input logic [15:0] ci);
    drive(8'h02, cr[15:8]);
    drive(8'h02, cr[7:0]);
    drive(8'h04, ci[15:8]);
    drive(8'h04, ci[7:0]);
  endtask

  task automatic wait_done();
    int k = 0;
    while (!bus.uo_out[7] && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (!bus.uo_out[7]) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout: done never rose within 300 cycles");
    end
  endtask

  task automatic run(input string name, input logic [15:0] cr, input logic [15:0] ci, input logic [7:0] exp);
    load(cr, ci);
    drive(8'h01, 8'h00);
    wait_done();
    chk(name, bus.uo_out, exp);
  endtask

  initial begin
    bus.ena = 1'b1;
    bus.ui_in = '0;
    bus.uio_in = '0;
    repeat (3) @(negedge clk);
    chk("reset_uo_out", bus.uo_out, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);
    run("zero_point", 16'h0000, 16'h0000, 8'hFF);
    run("cr_1p0", 16'h1000, 16'h0000, 8'h83);
    run("cr_2p0", 16'h2000, 16'h0000, 8'h82);
    run("cr_m2p0", 16'hE000, 16'h0000, 8'hFF);
    run("cr_0p5", 16'h0800, 16'h0000, 8'h85);
    run("ci_1p0", 16'h0000, 16'h1000, 8'hFF);
    drive(8'h01, 8'h00);
    repeat (2) @(negedge clk);
    drive(8'h03, 8'h55);
    wait_done();
    chk("busy_noise_ignored", bus.uo_out, 8'hFF);
    run("restart_cr_0p5", 16'h0800, 16'h0000, 8'h85);
    drive(8'h01, 8'h00);
    wait_done();
    chk("repeat_start_same", bus.uo_out, 8'h85);
    load(16'h0000, 16'h0000);
    drive(8'h01, 8'h00);
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("mid_reset_uo_out", bus.uo_out, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run("after_reset_1p0", 16'h1000, 16'h0000, 8'h83);
    drive(8'h01, 8'h00);
    wait_done();
    chk("after_reset_again", bus.uo_out, 8'h83);
    for (int i = 0; i < 40; i++) begin
      load(16'($urandom_range(0, 16384)) - 16'h2000, 16'($urandom_range(0, 16384)) - 16'h2000);
      drive(8'h01, 8'h00);
      if ($urandom_range(0, 1) == 1) drive(8'($urandom_range(0, 7)), 8'($urandom));
      wait_done();
      @(negedge clk);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mandelbrot_accel.md
Name: mandelbrot_accel

Overview:
- Tiny Tapeout user block that computes the Mandelbrot escape-iteration count for one complex point c = Cr + i·Ci.
- Cr and Ci are 16-bit signed Q4.12 values, each loaded byte-serially over uio_in.
- A start strobe launches the iteration at one iteration per clock.
- uo_out reports a done flag and the 7-bit iteration count.

Parameters:
- MAX_ITER, 127, iteration cap; must be ≤ 127 so the count fits uo_out[6:0].
- FRAC, 12, number of fractional bits in the Q4.12 data format.

Ports:
- clk  in  1  system clock, all state updates on its rising edge.
- rst_n  in  1  reset, active-low, asynchronous assert.
- ena  in  1  design-select; ignored.
- ui_in  in  8  [0] start, [1] load_Cr, [2] load_Ci, [7:3] unused.
- uio_in  in  8  load data byte.
- uo_out  out  8  [7] done, [6:0] iteration count n.
- uio_out  out  8  tied 0.
- uio_oe  out  8  tied 0 (all uio are inputs).

Behaviour:
- Single clock, reset is asynchronous and active-low.
- Reset values: Cr = Ci = 0, zr = zi = 0, n = 0, busy = 0, done = 0. Therefore uo_out = 0x00.
- Loading (only when not busy):
  - load_Cr high for a cycle: Cr <= {Cr[7:0], uio_in}.
  - load_Ci high for a cycle: Ci <= {Ci[7:0], uio_in}.
  - So two cycles load the high byte then the low byte.
  - Both loads high in the same cycle: both registers shift in the same byte.
  - Loads while busy are ignored.
- Start: start high while not busy → next edge sets zr = zi = 0, n = 0, done = 0, busy = 1. Start while busy is ignored.
- Iteration cycle (busy=1), one per clock:
  - Compute zr², zi², zr·zi as signed 32-bit Q8.24 products. Compute mag = zr² + zi² in ≥33 bits.
  - If mag > 4.0 (strict; 4.0 = 1<<26 in Q8.24): busy <= 0, done <= 1, n unchanged.
  - Else if n == MAX_ITER: busy <= 0, done <= 1.
  - Else:
    - zr <= ((zr² − zi²) >>> 12) + Cr
    - zi <= ((2·zr·zi) >>> 12) + Ci
    - Both truncated to 16 bits (arithmetic shift, truncation toward −∞).
    - n <= n + 1.
- Range: results are defined for |Cr|, |Ci| ≤ 2.0. Under that condition and strict escape, |z| never leaves Q4.12 range, so no saturation logic is required. Outside that range the result is unspecified but must not hang; the MAX_ITER cap guarantees termination.
- Latency: result = n, done asserted (n+1) clocks after the start-capture edge.
- Output hold: done, n, Cr and Ci hold until the next start. uo_out[6:0] shows the live n while busy.
- New computation: start after done clears done and recomputes. Cr/Ci persist, so repeated start gives identical results.
- Mid-operation reset: rst_n low at any time immediately returns all state to reset values.

Decomposition:
- Shared package:
  - data width (16)
  - FRAC (12)
  - ESCAPE_THRESH constant (4.0 in Q8.24)
  - MAX_ITER default
  - ui_in bit-index constants (START=0, LOAD_CR=1, LOAD_CI=2)
- One natural sub-module, mandelbrot_step:
  - combinational block taking zr, zi, Cr, Ci
  - returns next zr, next zi and the escape flag
- Top holds the load registers, control FSM (IDLE/BUSY; done is a status bit) and output mapping.

Test Plan:
- Reset only → uo_out = 0x00, uio_oe = 0x00, uio_out = 0x00.
- Load Cr = 0x0000, Ci = 0x0000, start → done after 128 clocks, uo_out = 0xFF (done, n = 127).
- Load Cr = 0x1000 (1.0), Ci = 0 → uo_out = 0x83 (n = 3: z = 1, 2, 5, escape).
- Load Cr = 0x2000 (2.0), Ci = 0 → uo_out = 0x82. Cr = 0xE000 (−2.0) → uo_out = 0xFF (bounded at z = 2, mag = 4 not > 4).
- Cr = 0x0800 (0.5), Ci = 0 → uo_out = 0x85. Cr = 0, Ci = 0x1000 (i) → uo_out = 0xFF (period-2 cycle).
- Robustness:
  - pulse start and load_Cr mid-computation → result unchanged;
  - assert rst_n low mid-computation → uo_out = 0x00 immediately;
  - restart → same count as before.
